mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit feeding the common data bus; optional MUL_DIV_UNIT_FAST_MUL_EN gives single-cycle multiplies.
// Latency: accept at N, result_valid from N+33 (N+1 for multiplies with MUL_DIV_UNIT_FAST_MUL_EN).
// Backpressure: result held in DONE until cdb_grant; no new op is accepted until the unit is back in IDLE.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            delete_tag,
    input  logic            feed_valid,
    input  logic [2:0]      feed_op,
    input  logic [XLEN-1:0] feed_data_1,
    input  logic [XLEN-1:0] feed_data_2,
    input  logic [5:0]      feed_rrn,
    input  logic            feed_tag,
    input  logic            cdb_grant,
    output logic            next,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [5:0]      result_rrn
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              tag_q, tag_d;
    logic [5:0]        rrn_q, rrn_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2*XLEN-1:0] prod_q, prod_d;

    logic              accept, flush, is_mul;
    logic              s1_signed, s2_signed, neg1, neg2, neg_in;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, step_val;

    assign is_mul    = !feed_op[2];
    assign s1_signed = (feed_op == 3'd1) || (feed_op == 3'd2) || (feed_op == 3'd4) || (feed_op == 3'd6);
    assign s2_signed = (feed_op == 3'd1) || (feed_op == 3'd4) || (feed_op == 3'd6);
    assign neg1      = s1_signed && feed_data_1[XLEN-1];
    assign neg2      = s2_signed && feed_data_2[XLEN-1];
    assign mag1      = neg1 ? -feed_data_1 : feed_data_1;
    assign mag2      = neg2 ? -feed_data_2 : feed_data_2;

    // A zero divisor keeps the quotient positive so it stays all-ones; remainders take the dividend sign.
    assign neg_in = is_mul      ? (neg1 ^ neg2) :
                    !feed_op[1] ? ((neg1 ^ neg2) && (feed_data_2 != '0)) :
                                  neg1;

    assign accept = (state_q == IDLE) && feed_valid && !(delete_tag && feed_tag);
    assign flush  = delete_tag && tag_q;

    // prod_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
    assign rem_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, opa_q};
    assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    assign step_val = op_q[2] ? div_next : mul_next;

`ifdef MUL_DIV_UNIT_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

    function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic neg,
                                              input logic [2*XLEN-1:0] raw);
        logic [2*XLEN-1:0] full;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        full = neg ? -raw : raw;
        quo  = neg ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        rem  = neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        if (!op[2]) begin
            return (op == 3'd0) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        end
        return op[1] ? rem : quo;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        tag_d   = tag_q;
        rrn_d   = rrn_q;
        opa_d   = opa_q;
        prod_d  = prod_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = feed_op;
                    neg_d   = neg_in;
                    tag_d   = feed_tag;
                    rrn_d   = feed_rrn;
                    opa_d   = is_mul ? mag1 : mag2;
                    prod_d  = {{XLEN{1'b0}}, (is_mul ? mag2 : mag1)};
`ifdef MUL_DIV_UNIT_FAST_MUL_EN
                    if (is_mul) begin
                        state_d = DONE;
                        res_d   = fixup(feed_op, neg_in, fast_prod);
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    prod_d = step_val;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        res_d   = fixup(op_q, neg_q, step_val);
                    end
                end
            end
            DONE: begin
                if (flush || cdb_grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            tag_q   <= 1'b0;
            rrn_q   <= '0;
            opa_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            tag_q   <= tag_d;
            rrn_q   <= rrn_d;
            opa_q   <= opa_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
        end
    end

    assign next         = accept && reset;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = res_q;
    assign result_rrn   = rrn_q;
endmodule
